// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the clock-control blocks: the lock-sequencer state
// encoding and small elaboration-time helpers.
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } lock_state_t;

    localparam int RETRY_W = 4;
    localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow level signals entering the local clock domain,
// with a synchronous clear so callers can discard stale history.
module sync_2ff #(
    parameter int WIDTH_p = 1
) (
    input  logic               clk,
    input  logic               srst,
    input  logic [WIDTH_p-1:0] d,
    output logic [WIDTH_p-1:0] q
);

    logic [WIDTH_p-1:0] meta_reg;
    logic [WIDTH_p-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/clock_lock_sequencer.sv
// Brings the pixel PLL out of reset, waits for a stable LOCK and only then
// releases pixel-domain reset; retries a bounded number of times before faulting.
module clock_lock_sequencer
    import clock_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES_p   = 12,
    parameter int LOCK_TIMEOUT_p  = 12000,
    parameter int STABLE_CYCLES_p = 1200,
    parameter int MAX_RETRIES_p   = 3
) (
    input  logic         clk_12mhz_i,
    input  logic         reset_i,
    input  logic         pll_lock_i,
    output logic         pll_resetb_o,
    output logic         sys_reset_o,
    output logic         ready_o,
    output logic         fault_o,
    output logic         lost_o,
    output logic [3:0]   retry_count_o,
    output logic [2:0]   state_o
);

    localparam int CNT_W = $clog2(max3(HOLD_CYCLES_p, LOCK_TIMEOUT_p, STABLE_CYCLES_p)) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES_p - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_p - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES_p - 1);

    if (HOLD_CYCLES_p < 1 || LOCK_TIMEOUT_p < 1 || STABLE_CYCLES_p < 1 || MAX_RETRIES_p < 1)
    begin : g_param_check
        $error("clock_lock_sequencer: every cycle/retry parameter must be at least 1");
    end

    lock_state_t        state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [RETRY_W-1:0] retry_reg, retry_next;
    logic               lost_reg, lost_next;
    logic               lock_sync;
    logic               sync_clr;

    // LOCK from a PLL held in reset is meaningless; flushing the synchronizer
    // in HOLD keeps a stale high from a previous attempt out of WAIT_LOCK.
    assign sync_clr = reset_i || (state_reg == ST_HOLD);

    sync_2ff #(
        .WIDTH_p (1)
    ) u_lock_sync (
        .clk  (clk_12mhz_i),
        .srst (sync_clr),
        .d    (pll_lock_i),
        .q    (lock_sync)
    );

    always_ff @(posedge clk_12mhz_i) begin
        if (reset_i) begin
            state_reg <= ST_HOLD;
            cnt_reg   <= '0;
            retry_reg <= '0;
            lost_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            retry_reg <= retry_next;
            lost_reg  <= lost_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;
        lost_next  = lost_reg;
        unique case (state_reg)
            ST_HOLD: begin
                if (cnt_reg == HOLD_LAST) state_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // A lock seen on the last timeout cycle wins over the timeout.
                if (lock_sync) begin
                    state_next = ST_STABLE;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    if (int'(retry_reg) == MAX_RETRIES_p) begin
                        state_next = ST_FAULT;
                    end else begin
                        state_next = ST_HOLD;
                        retry_next = (retry_reg == RETRY_SAT) ? retry_reg : retry_reg + 1'b1;
                    end
                end
            end
            ST_STABLE: begin
                if (!lock_sync) begin
                    state_next = ST_WAIT_LOCK;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next = ST_RUN;
                    retry_next = '0;
                end
            end
            ST_RUN: begin
                if (!lock_sync) begin
                    state_next = ST_HOLD;
                    lost_next  = 1'b1;
                end
            end
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_HOLD;
        endcase
    end

    // Counter restarts on every state change and idles in the terminal states.
    always_comb begin
        cnt_next = cnt_reg;
        if (state_next != state_reg) begin
            cnt_next = '0;
        end else if (state_reg != ST_RUN && state_reg != ST_FAULT) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    assign pll_resetb_o  = !(state_reg == ST_HOLD || state_reg == ST_FAULT);
    assign sys_reset_o   = (state_reg != ST_RUN);
    assign ready_o       = (state_reg == ST_RUN);
    assign fault_o       = (state_reg == ST_FAULT);
    assign lost_o        = lost_reg;
    assign retry_count_o = retry_reg;
    assign state_o       = state_reg;

endmodule

// File: tb/tb_clock_lock_sequencer.sv
// Directed scoreboard bench: each scenario queues the state transitions it
// expects (cycle, state, outputs); a monitor pops one per observed transition.
module tb_clock_lock_sequencer;

    localparam logic [2:0] S_HOLD   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_STABLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_FAULT  = 3'd4;

    logic       clk_12mhz_i = 1'b0;
    logic       reset_i     = 1'b1;
    logic       pll_lock_i  = 1'b0;
    logic       pll_resetb_o;
    logic       sys_reset_o;
    logic       ready_o;
    logic       fault_o;
    logic       lost_o;
    logic [3:0] retry_count_o;
    logic [2:0] state_o;

    clock_lock_sequencer #(
        .HOLD_CYCLES_p   (4),
        .LOCK_TIMEOUT_p  (20),
        .STABLE_CYCLES_p (8),
        .MAX_RETRIES_p   (2)
    ) dut (
        .clk_12mhz_i   (clk_12mhz_i),
        .reset_i       (reset_i),
        .pll_lock_i    (pll_lock_i),
        .pll_resetb_o  (pll_resetb_o),
        .sys_reset_o   (sys_reset_o),
        .ready_o       (ready_o),
        .fault_o       (fault_o),
        .lost_o        (lost_o),
        .retry_count_o (retry_count_o),
        .state_o       (state_o)
    );

    always #5 clk_12mhz_i = ~clk_12mhz_i;

    typedef struct packed {
        logic [2:0] st;
        logic       rb;
        logic       sr;
        logic       rdy;
        logic       flt;
        logic       lst;
        logic [3:0] rc;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t o;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_abs = 0;
    int   base    = 0;
    bit   mon_en  = 0;

    always @(posedge clk_12mhz_i) cyc_abs <= cyc_abs + 1;

    // Expected output set of a state, straight from the output table.
    task automatic push(input int c, input logic [2:0] st, input logic lst, input logic [3:0] rc);
        exp_t e;
        e.cyc   = c;
        e.o.st  = st;
        e.o.rb  = !(st == S_HOLD || st == S_FAULT);
        e.o.sr  = (st != S_RUN);
        e.o.rdy = (st == S_RUN);
        e.o.flt = (st == S_FAULT);
        e.o.lst = lst;
        e.o.rc  = rc;
        sb_q.push_back(e);
    endtask

    // One-cycle reset; the cycle after the sampling edge is cycle 0.
    task automatic do_reset();
        push(0, S_HOLD, 1'b0, 4'd0);
        @(negedge clk_12mhz_i);
        reset_i = 1'b1;
        @(posedge clk_12mhz_i);
        #1;
        reset_i = 1'b0;
        base    = cyc_abs;
        mon_en  = 1'b1;
    endtask

    task automatic at_cycle(input int t);
        while ((cyc_abs - base) < t) begin
            @(posedge clk_12mhz_i);
            #1;
        end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            @(posedge clk_12mhz_i);
            #1;
            k++;
        end
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected transitions pending, required 0 within %0d cycles",
                     sb_q.size(), budget);
            sb_q.delete();
        end
        repeat (4) begin
            @(posedge clk_12mhz_i);
            #1;
        end
    endtask

    initial begin : monitor
        logic [2:0] prev;
        obs_t       cur;
        exp_t       e;
        int         rel;
        prev = 3'b111;
        forever begin
            @(negedge clk_12mhz_i);
            if (mon_en) begin
                cur = {state_o, pll_resetb_o, sys_reset_o, ready_o, fault_o, lost_o, retry_count_o};
                rel = cyc_abs - base;
                if (cur.st !== prev) begin
                    prev = cur.st;
                    n_tests++;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_transition: cycle %0d got state=%0d, required no transition",
                                 rel, cur.st);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.cyc != rel || e.o !== cur) begin
                            n_fail++;
                            $display("FAIL to_state_%0d: got cycle %0d obs=%b, required cycle %0d obs=%b",
                                     e.o.st, rel, cur, e.cyc, e.o);
                        end else begin
                            $display("[TB] cycle %0d state=%0d resetb=%b sysrst=%b ready=%b fault=%b lost=%b retry=%0d ok",
                                     rel, cur.st, cur.rb, cur.sr, cur.rdy, cur.flt, cur.lst, cur.rc);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        repeat (3) @(posedge clk_12mhz_i);
        #1;

        // Constant lock: release, then a one-cycle loss in RUN and recovery.
        pll_lock_i = 1'b1;
        do_reset();
        push(4,  S_WAIT,   1'b0, 4'd0);
        push(7,  S_STABLE, 1'b0, 4'd0);
        push(15, S_RUN,    1'b0, 4'd0);
        push(23, S_HOLD,   1'b1, 4'd0);
        push(27, S_WAIT,   1'b1, 4'd0);
        push(30, S_STABLE, 1'b1, 4'd0);
        push(38, S_RUN,    1'b1, 4'd0);
        at_cycle(20);
        pll_lock_i = 1'b0;
        at_cycle(21);
        pll_lock_i = 1'b1;
        drain(40);

        // Reset while in RUN with lost set.
        do_reset();
        push(4,  S_WAIT,   1'b0, 4'd0);
        push(7,  S_STABLE, 1'b0, 4'd0);
        push(15, S_RUN,    1'b0, 4'd0);
        drain(30);

        // Lock glitch during STABLE falls back to WAIT_LOCK without a retry.
        do_reset();
        pll_lock_i = 1'b0;
        push(4,  S_WAIT,   1'b0, 4'd0);
        push(9,  S_STABLE, 1'b0, 4'd0);
        push(15, S_WAIT,   1'b0, 4'd0);
        push(16, S_STABLE, 1'b0, 4'd0);
        push(24, S_RUN,    1'b0, 4'd0);
        at_cycle(6);
        pll_lock_i = 1'b1;
        at_cycle(12);
        pll_lock_i = 1'b0;
        at_cycle(13);
        pll_lock_i = 1'b1;
        drain(40);

        // Lock raised too late to beat the timeout: one retry, RUN clears it.
        do_reset();
        pll_lock_i = 1'b0;
        push(4,  S_WAIT,   1'b0, 4'd0);
        push(24, S_HOLD,   1'b0, 4'd1);
        push(28, S_WAIT,   1'b0, 4'd1);
        push(31, S_STABLE, 1'b0, 4'd1);
        push(39, S_RUN,    1'b0, 4'd0);
        at_cycle(22);
        pll_lock_i = 1'b1;
        drain(50);

        // Lock synchronized on the last timeout cycle: STABLE wins.
        do_reset();
        pll_lock_i = 1'b0;
        push(4,  S_WAIT,   1'b0, 4'd0);
        push(24, S_STABLE, 1'b0, 4'd0);
        push(32, S_RUN,    1'b0, 4'd0);
        at_cycle(21);
        pll_lock_i = 1'b1;
        drain(40);

        // No lock at all: three attempts then sticky FAULT.
        do_reset();
        pll_lock_i = 1'b0;
        push(4,  S_WAIT,  1'b0, 4'd0);
        push(24, S_HOLD,  1'b0, 4'd1);
        push(28, S_WAIT,  1'b0, 4'd1);
        push(48, S_HOLD,  1'b0, 4'd2);
        push(52, S_WAIT,  1'b0, 4'd2);
        push(72, S_FAULT, 1'b0, 4'd2);
        drain(90);
        at_cycle(85);
        n_tests++;
        if (fault_o !== 1'b1 || pll_resetb_o !== 1'b0 || sys_reset_o !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_sticky: got fault=%b resetb=%b sysrst=%b, required 1 0 1",
                     fault_o, pll_resetb_o, sys_reset_o);
        end else begin
            $display("[TB] cycle 85 fault held fault=1 resetb=0 sysrst=1 ok");
        end

        // Reset out of FAULT restarts acquisition.
        do_reset();
        push(4, S_WAIT, 1'b0, 4'd0);
        drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
